// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM encoding,
// the NOP reset word and the default boot address.
package fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_BOOT = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_HOLD = 3'd3,
    ST_HALT = 3'd4
  } state_t;

  localparam logic [31:0] NOP_INST     = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding imem read, registered hand-off to decode.
// Optional macro FETCH_MISALIGN_CHK_EN halts with a sticky fault on a misaligned next PC.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic [XLEN-1:0] pc_next,
  output logic            fetch_fault
);

  state_t            state_q, state_d;
  logic              req_valid_q, req_valid_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              inst_valid_q, inst_valid_d;
  logic [31:0]       inst_q, inst_d;
  logic [XLEN-1:0]   inst_pc_q, inst_pc_d;
`ifdef FETCH_MISALIGN_CHK_EN
  logic              fault_q, fault_d;
`endif

  always_comb begin
    state_d      = state_q;
    req_valid_d  = req_valid_q;
    pc_d         = pc_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
`ifdef FETCH_MISALIGN_CHK_EN
    fault_d      = fault_q;
`endif
    unique case (state_q)
      ST_BOOT: begin
        state_d     = ST_REQ;
        req_valid_d = 1'b1;
      end
      ST_REQ: begin
        if (imem_req_ready) begin
          state_d     = ST_WAIT;
          req_valid_d = 1'b0;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          state_d      = ST_HOLD;
          inst_d       = imem_rsp_data;
          inst_pc_d    = pc_q;
          inst_valid_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (inst_ready) begin
          inst_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
          pc_d = pc_next;
          if (pc_next[1:0] != 2'b00) begin
            state_d = ST_HALT;
            fault_d = 1'b1;
          end else begin
            state_d     = ST_REQ;
            req_valid_d = 1'b1;
          end
`else
          // Low address bits are dropped silently; fetch never stalls on alignment.
          pc_d        = pc_next & ~(XLEN'(3));
          state_d     = ST_REQ;
          req_valid_d = 1'b1;
`endif
        end
      end
      ST_HALT: begin
        req_valid_d  = 1'b0;
        inst_valid_d = 1'b0;
      end
      default: begin
        state_d      = ST_BOOT;
        req_valid_d  = 1'b0;
        inst_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BOOT;
      req_valid_q  <= 1'b0;
      pc_q         <= RESET_PC;
      inst_valid_q <= 1'b0;
      inst_q       <= NOP_INST;
      inst_pc_q    <= RESET_PC;
`ifdef FETCH_MISALIGN_CHK_EN
      fault_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      req_valid_q  <= req_valid_d;
      pc_q         <= pc_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
`ifdef FETCH_MISALIGN_CHK_EN
      fault_q      <= fault_d;
`endif
    end
  end

  // The PC register doubles as the request address, so the address is held for free.
  assign imem_req_valid = req_valid_q;
  assign imem_addr      = pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
`ifdef FETCH_MISALIGN_CHK_EN
  assign fetch_fault    = fault_q;
`else
  assign fetch_fault    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed fetch sequences push expected
// request addresses and instructions; a negedge monitor pops and compares.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc_next;
  logic        fetch_fault;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int last_hs = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_inst_q[$];
  logic [31:0] exp_ipc_q[$];

  fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .pc_next        (pc_next),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every request handshake and every decode consume is scored.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (imem_req_valid && imem_req_ready) begin
        if (exp_addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: got addr %h expected no request", imem_addr);
        end else chk("req_addr", imem_addr, exp_addr_q.pop_front());
      end
      if (inst_valid && inst_ready) begin
        if (exp_inst_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_inst: got %h expected no instruction", inst);
        end else begin
          chk("inst", inst, exp_inst_q.pop_front());
          chk("inst_pc", inst_pc, exp_ipc_q.pop_front());
        end
      end
    end
  end

  task automatic fetch_one(input logic [31:0] a, input logic [31:0] d,
                           input int rstall, input int hstall, input logic [31:0] nxt);
    int n;
    exp_addr_q.push_back(a);
    exp_inst_q.push_back(d);
    exp_ipc_q.push_back(a);
    n = 0;
    while (!imem_req_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!imem_req_valid) begin
      checks++; errors++;
      $display("FAIL req_timeout: got valid 0 expected valid 1 for addr %h", a);
      void'(exp_addr_q.pop_back());
      void'(exp_inst_q.pop_back());
      void'(exp_ipc_q.pop_back());
      return;
    end
    for (int i = 0; i < rstall; i++) begin
      chk("req_hold_addr", imem_addr, a);
      chk("req_hold_valid", 32'(imem_req_valid), 32'd1);
      @(posedge clk); #1;
    end
    imem_req_ready = 1'b1;
    @(posedge clk); #1;
    last_hs = cyc;
    imem_req_ready = 1'b0;
    chk("req_drop", 32'(imem_req_valid), 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = d;
    @(posedge clk); #1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    chk("inst_valid_lat", 32'(inst_valid), 32'd1);
    for (int i = 0; i < hstall; i++) begin
      chk("hold_inst", inst, d);
      chk("hold_pc", inst_pc, a);
      chk("hold_noreq", 32'(imem_req_valid), 32'd0);
      @(posedge clk); #1;
    end
    inst_ready = 1'b1;
    pc_next    = nxt;
    @(posedge clk); #1;
    inst_ready = 1'b0;
    pc_next    = 32'hBAD0_0001;
    chk("consume_drop", 32'(inst_valid), 32'd0);
  endtask

  initial begin
    int h1, h2, h3;
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    inst_ready     = 1'b0;
    pc_next        = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'h0000_0013);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    rst_n = 1'b1;
    chk("boot_no_req", 32'(imem_req_valid), 32'd0);
    @(posedge clk); #1;
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_addr, 32'h0);

    fetch_one(32'h0, 32'h0050_0093, 5, 4, 32'h4);
    chk("next_req_valid", 32'(imem_req_valid), 32'd1);
    chk("next_req_addr", imem_addr, 32'h4);

    fetch_one(32'h4, 32'h0010_8093, 0, 0, 32'h8);
    h1 = last_hs;
    fetch_one(32'h8, 32'h0020_8093, 0, 0, 32'hC);
    h2 = last_hs;
    fetch_one(32'hC, 32'h0030_8093, 0, 0, 32'h100);
    h3 = last_hs;
    chk("tput_a", 32'(h2 - h1), 32'd3);
    chk("tput_b", 32'(h3 - h2), 32'd3);
    chk("branch_addr", imem_addr, 32'h100);

    fetch_one(32'h100, 32'h0000_006F, 0, 0, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    fetch_one(32'hFFFF_FFFC, 32'h00A0_0113, 0, 0, 32'h102);

`ifdef FETCH_MISALIGN_CHK_EN
    imem_req_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("halt_fault", 32'(fetch_fault), 32'd1);
      chk("halt_noreq", 32'(imem_req_valid), 32'd0);
      chk("halt_noinst", 32'(inst_valid), 32'd0);
      chk("halt_addr", imem_addr, 32'h102);
      imem_rsp_valid = (i == 2);
      @(posedge clk); #1;
    end
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
`else
    chk("nofault", 32'(fetch_fault), 32'd0);
    chk("misalign_cleared_addr", imem_addr, 32'h100);
    fetch_one(32'h100, 32'h0000_0033, 0, 0, 32'h200);
`endif

    // Reset while a response is outstanding; a late response must be dropped.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_addr_q.push_back(32'h0);
    @(posedge clk); #1;
    imem_req_ready = 1'b1;
    @(posedge clk); #1;
    imem_req_ready = 1'b0;
    chk("wait_entered", 32'(imem_req_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_fault", 32'(fetch_fault), 32'd0);
    chk("rst_mid_inst_valid", 32'(inst_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n          = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    chk("stale_inst_valid", 32'(inst_valid), 32'd0);
    chk("stale_inst", inst, 32'h0000_0013);
    chk("restart_req", 32'(imem_req_valid), 32'd1);
    chk("restart_addr", imem_addr, 32'h0);
    @(posedge clk); #1;
    chk("stale_still_ignored", 32'(inst_valid), 32'd0);
    fetch_one(32'h0, 32'h0050_0093, 0, 0, 32'h4);

    repeat (2) @(posedge clk);
    #1;
    chk("addr_q_drained", 32'(exp_addr_q.size()), 32'd0);
    chk("inst_q_drained", 32'(exp_inst_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer. Owns the architectural PC register and issues one instruction-memory read at a time over a valid/ready request channel.
- Captures the returned word and presents it to decode with a valid/ready handshake.
- Consumes the next-PC value computed by the branch/next-PC logic when decode accepts the instruction. It closes the loop between next-PC computation and instruction memory.

Parameters:
XLEN, 32, data and address width
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_req_valid  output  1  read request valid
imem_req_ready  input  1  memory accepts request
imem_addr  output  XLEN  read address, stable while imem_req_valid=1
imem_rsp_valid  input  1  read data valid, one-cycle pulse
imem_rsp_data  input  32  instruction word
inst_valid  output  1  instruction available to decode
inst_ready  input  1  decode consumes instruction
inst  output  32  instruction word
inst_pc  output  XLEN  address of inst
pc_next  input  XLEN  next PC from next-PC logic; sampled only when inst_valid&inst_ready
fetch_fault  output  1  sticky misaligned-target flag (macro-dependent)

Behaviour:
- Reset values (async, rst_n=0): state=BOOT, imem_req_valid=0, imem_addr=RESET_PC, inst_valid=0, inst=32'h0000_0013 (NOP), inst_pc=RESET_PC, fetch_fault=0.
- All outputs are registered.
- FSM states: BOOT, REQ, WAIT, HOLD, HALT.
  - BOOT: always moves to REQ on the next edge. The first imem_req_valid=1 appears on the first cycle after reset release.
  - REQ: imem_req_valid=1, imem_addr=PC. On imem_req_ready=1: go to WAIT and drop imem_req_valid on the next edge. Otherwise stay; addr is held.
  - WAIT: on imem_rsp_valid=1: inst<=imem_rsp_data, inst_pc<=PC, inst_valid<=1, go to HOLD. The instruction is visible the cycle after the response.
  - HOLD: inst_valid=1; inst and inst_pc are held stable until inst_ready=1. On inst_ready=1:
    - inst_valid<=0, PC<=pc_next, imem_addr<=pc_next, go to REQ. The new request is visible one cycle after the consume.
    - Misaligned pc_next (see Optional Feature) goes to HALT instead.
  - HALT: all valids 0; remains until reset.
- Exactly one outstanding request at any time.
- imem_rsp_valid outside WAIT is a protocol violation and is ignored; state and data are unchanged.
- imem_rsp_valid in the same cycle as the request handshake is not permitted. The response may arrive no earlier than the cycle after the handshake.
- Best-case loop latency: request handshake at t, response at t+1, inst_valid at t+2, consume at t+2, next request at t+3. Throughput is 1 instruction per 3 cycles.
- PC arithmetic: none internally. pc_next is taken as given, full XLEN, and wraps naturally at 2^XLEN.
- Reset mid-operation returns to BOOT. Any in-flight response is discarded: after reset, the first imem_rsp_valid before a new handshake is ignored because the state is not WAIT.
- inst_ready while inst_valid=0 has no effect.

Optional Feature:
- Macro: FETCH_MISALIGN_CHK_EN.
- Defined:
  - pc_next[1:0]!=0 at consume: fetch_fault<=1 (sticky until reset), PC and imem_addr<=pc_next unchanged, state<=HALT, no request issued.
- Undefined:
  - fetch_fault is tied to 0.
  - PC and imem_addr<={pc_next[XLEN-1:2],2'b00}. The low bits are silently cleared and fetch continues.

Decomposition:
- Shared package:
  - FSM state encoding: BOOT=0, REQ=1, WAIT=2, HOLD=3, HALT=4, 3 bits.
  - NOP constant 32'h0000_0013.
  - RESET_PC default.
- No sub-module: the FSM plus the PC/instruction registers are a single block. A separate reusable pc_reg sub-module is unnecessary.

Test Plan:
- Reset release, imem_req_ready=1: imem_req_valid=1, imem_addr=0x0 on the first post-reset cycle. Response 0x00500093 one cycle later gives inst_valid=1, inst=0x00500093, inst_pc=0x0 the following cycle.
- Backpressure: imem_req_ready=0 for 5 cycles → addr held at 0x0 and valid held at 1. inst_ready=0 for 4 cycles → inst and inst_pc stable, no new request.
- Sequential loop: pc_next=inst_pc+4 on each consume for 4 instructions → addresses 0x0, 0x4, 0x8, 0xC; 3 cycles per instruction.
- Branch target: consume with pc_next=0x100 → next imem_addr=0x100, inst_pc=0x100. Wrap case: pc_next=0xFFFF_FFFC → addr 0xFFFF_FFFC.
- Misaligned pc_next=0x102:
  - With the macro: fetch_fault=1, no further requests, stays in HALT until rst_n.
  - Without the macro: imem_addr=0x100.
- Reset asserted in WAIT, then released; a stale imem_rsp_valid is pulsed in BOOT → ignored, inst_valid=0, and the fetch restarts at RESET_PC.
